// File: rtl/mc_ctrl.sv
// Multi-cycle RV32I-subset control unit: sequences FETCH/DECODE/EXEC/MEM/WB,
// handles ready handshakes with a wait timeout, a sticky trap and instret.
module mc_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned CNT_W       = 32,
   parameter int unsigned EN_JALR     = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [6:0]       Op,
   input  logic [6:0]       Funct7,
   input  logic [2:0]       Funct3,
   input  logic             Zero,
   input  logic             Lt,
   input  logic             Ltu,
   input  logic             imem_ready,
   input  logic             dmem_ready,
   output logic             imem_req,
   output logic             IRWrite,
   output logic             PCWrite,
   output logic             RegWrite,
   output logic             MemRead,
   output logic             MemWrite,
   output logic [5:0]       EXTOp,
   output logic [4:0]       ALUOp,
   output logic [2:0]       NPCOp,
   output logic             ALUSrc,
   output logic [1:0]       WDSel,
   output logic [2:0]       DMType,
   output logic             trap,
   output logic [CNT_W-1:0] instret,
   output logic [2:0]       state
);

   localparam int unsigned TO_W = 8;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IALU   = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   localparam logic [4:0] ALU_NOP  = 5'b00000;
   localparam logic [4:0] ALU_LUI  = 5'b00001;
   localparam logic [4:0] ALU_ADD  = 5'b00011;
   localparam logic [4:0] ALU_SUB  = 5'b00100;
   localparam logic [4:0] ALU_SLT  = 5'b01010;
   localparam logic [4:0] ALU_SLTU = 5'b01011;
   localparam logic [4:0] ALU_XOR  = 5'b01100;
   localparam logic [4:0] ALU_OR   = 5'b01101;
   localparam logic [4:0] ALU_AND  = 5'b01110;
   localparam logic [4:0] ALU_SLL  = 5'b01111;
   localparam logic [4:0] ALU_SRL  = 5'b10000;
   localparam logic [4:0] ALU_SRA  = 5'b10001;

   localparam logic [5:0] EXT_SHAMT = 6'b100000;
   localparam logic [5:0] EXT_I     = 6'b010000;
   localparam logic [5:0] EXT_S     = 6'b001000;
   localparam logic [5:0] EXT_B     = 6'b000100;
   localparam logic [5:0] EXT_U     = 6'b000010;
   localparam logic [5:0] EXT_J     = 6'b000001;

   localparam logic [2:0] NPC_PLUS4  = 3'b000;
   localparam logic [2:0] NPC_BRANCH = 3'b001;
   localparam logic [2:0] NPC_JUMP   = 3'b010;
   localparam logic [2:0] NPC_JALR   = 3'b100;

   localparam logic [1:0] WD_ALU = 2'b00;
   localparam logic [1:0] WD_MEM = 2'b01;
   localparam logic [1:0] WD_PC4 = 2'b10;

   typedef enum logic [2:0] {
      S_FETCH  = 3'b000,
      S_DECODE = 3'b001,
      S_EXEC   = 3'b010,
      S_MEM    = 3'b011,
      S_WB     = 3'b100,
      S_TRAP   = 3'b111
   } state_t;

   state_t           state_q, state_d;
   logic [TO_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0] instret_q, instret_d;

   logic       is_r, is_ialu, is_load, is_store, is_branch, is_lui, is_jal, is_jalr;
   logic       legal, br_taken, alu_src, timeout_hit;
   logic [4:0] alu_op, alu_fn;
   logic [5:0] ext_op;
   logic [2:0] dm_type;

   // Opcode classification and legality
   always_comb begin
      is_r      = (Op == OP_R);
      is_ialu   = (Op == OP_IALU);
      is_load   = (Op == OP_LOAD);
      is_store  = (Op == OP_STORE);
      is_branch = (Op == OP_BRANCH);
      is_lui    = (Op == OP_LUI);
      is_jal    = (Op == OP_JAL);
      is_jalr   = (Op == OP_JALR) && (EN_JALR != 0) && (Funct3 == 3'b000);
      legal     = 1'b0;
      if (is_r)
         legal = (Funct7 == 7'b0000000) ||
                 ((Funct7 == 7'b0100000) && ((Funct3 == 3'b000) || (Funct3 == 3'b101)));
      else if (is_ialu)
         legal = (Funct3 == 3'b001) ? (Funct7 == 7'b0000000) :
                 (Funct3 == 3'b101) ? ((Funct7 == 7'b0000000) || (Funct7 == 7'b0100000)) :
                 1'b1;
      else if (is_load)
         legal = (Funct3 != 3'b011) && (Funct3 != 3'b110) && (Funct3 != 3'b111);
      else if (is_store)
         legal = (Funct3 == 3'b000) || (Funct3 == 3'b001) || (Funct3 == 3'b010);
      else if (is_branch)
         legal = (Funct3 != 3'b010) && (Funct3 != 3'b011);
      else
         legal = is_lui || is_jal || is_jalr;
   end

   // Datapath selects; held from EXEC through WB so the ALU result stays valid
   always_comb begin
      case (Funct3)
         3'b000:  alu_fn = (is_r && Funct7[5]) ? ALU_SUB : ALU_ADD;
         3'b001:  alu_fn = ALU_SLL;
         3'b010:  alu_fn = ALU_SLT;
         3'b011:  alu_fn = ALU_SLTU;
         3'b100:  alu_fn = ALU_XOR;
         3'b101:  alu_fn = Funct7[5] ? ALU_SRA : ALU_SRL;
         3'b110:  alu_fn = ALU_OR;
         default: alu_fn = ALU_AND;
      endcase
      alu_op  = ALU_NOP;
      alu_src = 1'b0;
      ext_op  = 6'b000000;
      if (is_r) begin
         alu_op = alu_fn;
      end else if (is_ialu) begin
         alu_op  = alu_fn;
         alu_src = 1'b1;
         ext_op  = ((Funct3 == 3'b001) || (Funct3 == 3'b101)) ? EXT_SHAMT : EXT_I;
      end else if (is_load || is_jalr) begin
         alu_op  = ALU_ADD;
         alu_src = 1'b1;
         ext_op  = EXT_I;
      end else if (is_store) begin
         alu_op  = ALU_ADD;
         alu_src = 1'b1;
         ext_op  = EXT_S;
      end else if (is_branch) begin
         alu_op = ALU_SUB;
         ext_op = EXT_B;
      end else if (is_lui) begin
         alu_op  = ALU_LUI;
         alu_src = 1'b1;
         ext_op  = EXT_U;
      end else if (is_jal) begin
         ext_op = EXT_J;
      end

      case (Funct3)
         3'b000:  dm_type = 3'b011;
         3'b001:  dm_type = 3'b001;
         3'b100:  dm_type = 3'b100;
         3'b101:  dm_type = 3'b010;
         default: dm_type = 3'b000;
      endcase

      case (Funct3)
         3'b000:  br_taken = Zero;
         3'b001:  br_taken = ~Zero;
         3'b100:  br_taken = Lt;
         3'b101:  br_taken = ~Lt;
         3'b110:  br_taken = Ltu;
         default: br_taken = ~Ltu;
      endcase
   end

   assign timeout_hit = ({1'b0, cnt_q} + 9'd1) == 9'(MEM_TIMEOUT);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_FETCH;
         cnt_q     <= '0;
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         instret_q <= instret_d;
      end
   end

   // Next state, counters and control outputs
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      instret_d = instret_q;
      imem_req  = 1'b0;
      IRWrite   = 1'b0;
      PCWrite   = 1'b0;
      RegWrite  = 1'b0;
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      EXTOp     = 6'b000000;
      ALUOp     = ALU_NOP;
      NPCOp     = NPC_PLUS4;
      ALUSrc    = 1'b0;
      WDSel     = WD_ALU;
      DMType    = 3'b000;
      case (state_q)
         S_FETCH: begin
            imem_req = 1'b1;
            if (imem_ready) begin
               IRWrite = 1'b1;
               state_d = S_DECODE;
            end else if (timeout_hit) begin
               state_d = S_TRAP;
            end else begin
               cnt_d = cnt_q + TO_W'(1);
            end
         end
         S_DECODE: state_d = legal ? S_EXEC : S_TRAP;
         S_EXEC: begin
            ALUOp  = alu_op;
            ALUSrc = alu_src;
            EXTOp  = ext_op;
            if (is_branch) begin
               NPCOp     = br_taken ? NPC_BRANCH : NPC_PLUS4;
               PCWrite   = 1'b1;
               instret_d = instret_q + CNT_W'(1);
               cnt_d     = '0;
               state_d   = S_FETCH;
            end else if (is_load || is_store) begin
               cnt_d   = '0;
               state_d = S_MEM;
            end else begin
               state_d = S_WB;
            end
         end
         S_MEM: begin
            ALUOp    = alu_op;
            ALUSrc   = alu_src;
            EXTOp    = ext_op;
            DMType   = dm_type;
            MemRead  = is_load;
            MemWrite = is_store;
            if (dmem_ready) begin
               if (is_load) begin
                  state_d = S_WB;
               end else begin
                  PCWrite   = 1'b1;
                  instret_d = instret_q + CNT_W'(1);
                  cnt_d     = '0;
                  state_d   = S_FETCH;
               end
            end else if (timeout_hit) begin
               state_d = S_TRAP;
            end else begin
               cnt_d = cnt_q + TO_W'(1);
            end
         end
         S_WB: begin
            ALUOp     = alu_op;
            ALUSrc    = alu_src;
            EXTOp     = ext_op;
            RegWrite  = 1'b1;
            PCWrite   = 1'b1;
            DMType    = is_load ? dm_type : 3'b000;
            WDSel     = is_load ? WD_MEM : ((is_jal || is_jalr) ? WD_PC4 : WD_ALU);
            NPCOp     = is_jal ? NPC_JUMP : (is_jalr ? NPC_JALR : NPC_PLUS4);
            instret_d = instret_q + CNT_W'(1);
            cnt_d     = '0;
            state_d   = S_FETCH;
         end
         S_TRAP:  state_d = S_TRAP;
         default: state_d = S_TRAP;
      endcase
      // Reset forces every output low, even before the register clears
      if (reset) begin
         imem_req = 1'b0;
         IRWrite  = 1'b0;
         PCWrite  = 1'b0;
         RegWrite = 1'b0;
         MemRead  = 1'b0;
         MemWrite = 1'b0;
         EXTOp    = 6'b000000;
         ALUOp    = ALU_NOP;
         NPCOp    = NPC_PLUS4;
         ALUSrc   = 1'b0;
         WDSel    = WD_ALU;
         DMType   = 3'b000;
      end
   end

   assign trap    = (state_q == S_TRAP) && !reset;
   assign instret = reset ? '0 : instret_q;
   assign state   = reset ? 3'b000 : state_q;

endmodule
